// File: rtl/npc_pkg.sv
// Shared LSU definitions: load-type encodings, store byte-count masks, FSM states
// and the alignment rule used when LSU_MISALIGN_CHECK_EN is defined.
package npc_pkg;

   localparam logic [2:0] RT_LB  = 3'd0;
   localparam logic [2:0] RT_LH  = 3'd1;
   localparam logic [2:0] RT_LW  = 3'd2;
   localparam logic [2:0] RT_LBU = 3'd3;
   localparam logic [2:0] RT_LHU = 3'd4;

   localparam logic [7:0] WMASK_B = 8'h01;
   localparam logic [7:0] WMASK_H = 8'h03;
   localparam logic [7:0] WMASK_W = 8'h0F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // Loads with rtype 5-7 count as word accesses, matching their lw behaviour.
   function automatic logic is_misaligned(input logic       wen,
                                          input logic [7:0] wmask,
                                          input logic [2:0] rtype,
                                          input logic [1:0] off);
      logic half;
      logic word;
      if (wen) begin
         half = (wmask == WMASK_H);
         word = (wmask == WMASK_W);
      end else begin
         half = (rtype == RT_LH) || (rtype == RT_LHU);
         word = !half && (rtype != RT_LB) && (rtype != RT_LBU);
      end
      return (half && off[0]) || (word && (off != 2'd0));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobe/data placement and load shift plus extension.
module lsu_align
   import npc_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wmask_i,
   input  logic [2:0]  rtype_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] rshift;

   // Bytes pushed past lane 3 fall off the word.
   assign wstrb_o = wmask_i << off_i;
   assign wdata_o = wdata_i << {off_i, 3'b000};
   assign rshift  = rdata_i >> {off_i, 3'b000};

   always_comb begin
      rdata_o = rshift;
      case (rtype_i)
         RT_LB:   rdata_o = {{24{rshift[7]}}, rshift[7:0]};
         RT_LH:   rdata_o = {{16{rshift[15]}}, rshift[15:0]};
         RT_LBU:  rdata_o = {24'h000000, rshift[7:0]};
         RT_LHU:  rdata_o = {16'h0000, rshift[15:0]};
         default: rdata_o = rshift;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> RESP.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word ops without a memory access.
module lsu
   import npc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_wen,
   input  logic [7:0]        req_wmask,
   input  logic [2:0]        req_rtype,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state_o
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("lsu: DATA_W must be 32");
   end

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wen_q, wen_d;
   logic [7:0]        wmask_q, wmask_d;
   logic [2:0]        rtype_q, rtype_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        al_wstrb;
   logic [31:0]       al_wdata;
   logic [31:0]       al_rdata;
   logic              unused_wmask_hi;

   assign unused_wmask_hi = |wmask_q[7:4];

   lsu_align u_align (
      .off_i   (addr_q[1:0]),
      .wdata_i (wdata_q),
      .wmask_i (wmask_q[3:0]),
      .rtype_i (rtype_q),
      .rdata_i (mem_rdata),
      .wstrb_o (al_wstrb),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

`ifdef LSU_MISALIGN_CHECK_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wen_d   = wen_q;
      wmask_d = wmask_q;
      rtype_d = rtype_q;
      rdata_d = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wen_d   = req_wen;
               wmask_d = req_wmask;
               rtype_d = req_rtype;
               rdata_d = 32'h0;
               state_d = ST_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
               err_d   = 1'b0;
               // Faulting ops answer straight away and never reach memory.
               if (is_misaligned(req_wen, req_wmask, req_rtype, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
`endif
            end
         end
         ST_REQ: begin
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               rdata_d = wen_q ? 32'h0 : al_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         wen_q   <= 1'b0;
         wmask_q <= 8'h00;
         rtype_q <= 3'd0;
         rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         wmask_q <= wmask_d;
         rtype_q <= rtype_d;
         rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

   assign req_ready     = (state_q == ST_IDLE);
   assign mem_req_valid = (state_q == ST_REQ);
   assign resp_valid    = (state_q == ST_RESP);
   assign resp_rdata    = rdata_q;
   assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wen       = wen_q;
   assign mem_wstrb     = wen_q ? al_wstrb : 4'h0;
   assign mem_wdata     = al_wdata;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random loads/stores against a byte-level model,
// with a scoreboard queue of expected responses.
module tb_lsu;
   import npc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr, req_wdata;
   logic        req_wen;
   logic [7:0]  req_wmask;
   logic [2:0]  req_rtype;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];

   always #5 clk = ~clk;

   lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wen(req_wen), .req_wmask(req_wmask), .req_rtype(req_rtype),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .dbg_state_o(dbg_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] rt);
      logic [7:0] by [0:6];
      logic [7:0] b;
      logic [15:0] h;
      for (int i = 0; i < 7; i++) by[i] = (i < 4) ? w[8*i +: 8] : 8'h00;
      b = by[off];
      h = {by[off+1], by[off]};
      case (rt)
         RT_LB:   return {{24{b[7]}}, b};
         RT_LH:   return {{16{h[15]}}, h};
         RT_LBU:  return {24'h0, b};
         RT_LHU:  return {16'h0, h};
         default: return {by[off+3], by[off+2], by[off+1], by[off]};
      endcase
   endfunction

   function automatic logic [3:0] model_strb(input logic [7:0] wmask, input int off);
      logic [3:0] s = 4'h0;
      for (int j = 0; j < 4; j++) if (wmask[j] && (j + off) < 4) s[j+off] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int off);
      logic [31:0] r = 32'h0;
      for (int j = 0; j < 4; j++) if ((j + off) < 4) r[8*(j+off) +: 8] = wd[8*j +: 8];
      return r;
   endfunction

   task automatic do_op(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                        input logic [7:0] wmask, input logic [2:0] rtype, input logic [31:0] mrdata,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic exp_err,
                        input int mstall, input int rstall, input bit chk_lat);
      int cyc;
      int lat;
      logic acc;
      logic [31:0] exp_addr;
      logic [31:0] e_rd;
      logic e_err;
      exp_addr = {addr[31:2], 2'b00};
      exp_q.push_back(exp_rdata);
      exp_err_q.push_back(exp_err);
      @(negedge clk);
      req_valid = 1'b1; req_addr = addr; req_wdata = wdata;
      req_wen = wen; req_wmask = wmask; req_rtype = rtype;
      cyc = 0; acc = 1'b0;
      while (!acc && cyc < 50) begin
         acc = req_ready;
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = 1'b0;
      check_eq("accept", acc, 1'b1);
      if (!acc) begin
         exp_q.delete(); exp_err_q.delete();
         return;
      end
      lat = 1;
      if (exp_err) begin
         @(negedge clk);
         check_eq("mis_no_mreq", mem_req_valid, 1'b0);
         check_eq("mis_resp_next", resp_valid, 1'b1);
      end else begin
         for (int i = 0; i < mstall; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_rdata = ~mrdata;
            check_eq("stall_mreq_valid", mem_req_valid, 1'b1);
            check_eq("stall_mem_addr", mem_addr, exp_addr);
            check_eq("stall_mem_wstrb", mem_wstrb, exp_strb);
            check_eq("stall_req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
            lat++;
         end
         mem_resp_valid = 1'b0;
         @(negedge clk);
         check_eq("mreq_valid", mem_req_valid, 1'b1);
         check_eq("mem_addr", mem_addr, exp_addr);
         check_eq("mem_wen", mem_wen, wen);
         check_eq("mem_wstrb", mem_wstrb, exp_strb);
         if (wen) check_eq("mem_wdata", mem_wdata, exp_wdata);
         mem_req_ready = 1'b1;
         @(posedge clk); #1;
         lat++;
         mem_req_ready = 1'b0;
         mem_resp_valid = 1'b1; mem_rdata = mrdata;
         @(posedge clk); #1;
         lat++;
         mem_resp_valid = 1'b0;
         @(negedge clk);
      end
      cyc = 0;
      while (!resp_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("resp_seen", resp_valid, 1'b1);
      if (!resp_valid) begin
         exp_q.delete(); exp_err_q.delete();
         return;
      end
      if (chk_lat) check_eq("latency", lat + cyc, 3);
      for (int i = 0; i < rstall; i++) begin
         check_eq("hold_resp_valid", resp_valid, 1'b1);
         check_eq("hold_resp_rdata", resp_rdata, exp_q[0]);
         check_eq("hold_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      e_rd = exp_q.pop_front();
      e_err = exp_err_q.pop_front();
      check_eq("resp_valid", resp_valid, 1'b1);
      check_eq("resp_rdata", resp_rdata, e_rd);
      check_eq("resp_err", resp_err, e_err);
      check_eq("req_ready_in_resp", req_ready, 1'b0);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check_eq("resp_single", resp_valid, 1'b0);
      check_eq("req_ready_after", req_ready, 1'b1);
   endtask

   task automatic reset_in_wait();
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b0;
      req_wmask = 8'h00; req_rtype = RT_LW; req_wdata = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      @(negedge clk);
      check_eq("rst_pre_state", dbg_state, ST_WAIT);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      check_eq("rst_req_ready", req_ready, 1'b1);
      check_eq("rst_no_resp", resp_valid, 1'b0);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_late_no_resp", resp_valid, 1'b0);
         check_eq("rst_late_no_mreq", mem_req_valid, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        wen;
      logic [7:0]  wmask;
      logic [2:0]  rt;
      int          size, off, kind;
      logic [31:0] addr, wd, mrd;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wen = 1'b0;
      req_wmask = 8'h00; req_rtype = 3'd0; resp_ready = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_req_ready", req_ready, 1'b1);
      check_eq("rst_mreq_valid", mem_req_valid, 1'b0);
      check_eq("rst_resp_valid", resp_valid, 1'b0);
      check_eq("rst_resp_err", resp_err, 1'b0);
      check_eq("rst_mem_wen", mem_wen, 1'b0);
      check_eq("rst_mem_wstrb", mem_wstrb, 4'h0);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      check_eq("rst_resp_rdata", resp_rdata, 32'h0);
      check_eq("rst_state", dbg_state, ST_IDLE);

      do_op(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, WMASK_W, RT_LW, 32'h1122_3344,
            32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b1);
      do_op(32'h8000_0003, 32'h0000_00AB, 1'b1, WMASK_B, RT_LW, 32'h5566_7788,
            32'h0, 4'h8, 32'hAB00_0000, 1'b0, 0, 0, 1'b1);
      do_op(32'h8000_0001, 32'h0, 1'b0, 8'h00, RT_LB,  32'h8000_FF7F,
            32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0, 0, 1'b1);
      do_op(32'h8000_0000, 32'h0, 1'b0, 8'h00, RT_LBU, 32'h8000_FF7F,
            32'h0000_007F, 4'h0, 32'h0, 1'b0, 0, 0, 1'b0);
      do_op(32'h8000_0002, 32'h0, 1'b0, 8'h00, RT_LH,  32'h8000_FF7F,
            32'hFFFF_8000, 4'h0, 32'h0, 1'b0, 0, 0, 1'b0);
      do_op(32'h8000_0002, 32'h0, 1'b0, 8'h00, RT_LHU, 32'h8000_FF7F,
            32'h0000_8000, 4'h0, 32'h0, 1'b0, 0, 0, 1'b0);
      do_op(32'h8000_0002, 32'h0000_BEEF, 1'b1, WMASK_H, RT_LW, 32'h0,
            32'h0, 4'hC, 32'hBEEF_0000, 1'b0, 5, 3, 1'b0);
      do_op(32'h8000_0008, 32'h0, 1'b0, 8'h00, 3'd6, 32'hCAFE_F00D,
            32'hCAFE_F00D, 4'h0, 32'h0, 1'b0, 0, 0, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
      do_op(32'h8000_0002, 32'h0, 1'b0, 8'h00, RT_LW, 32'hA5A5_1234,
            32'h0, 4'h0, 32'h0, 1'b1, 0, 0, 1'b0);
`else
      do_op(32'h8000_0002, 32'h0, 1'b0, 8'h00, RT_LW, 32'hA5A5_1234,
            32'h0000_A5A5, 4'h0, 32'h0, 1'b0, 0, 0, 1'b0);
`endif

      reset_in_wait();

      for (int n = 0; n < 16; n++) begin
         wen  = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 2);
         rt   = 3'($urandom_range(0, 7));
         if (wen) begin
            wmask = (kind == 0) ? WMASK_B : (kind == 1) ? WMASK_H : WMASK_W;
            size  = 1 << kind;
         end else begin
            wmask = 8'h00;
            size  = (rt == RT_LB || rt == RT_LBU) ? 1 : (rt == RT_LH || rt == RT_LHU) ? 2 : 4;
         end
         off  = size * $urandom_range(0, 4 / size - 1);
         addr = ($urandom() & 32'hFFFF_FFFC) | 32'(off);
         wd   = $urandom();
         mrd  = $urandom();
         do_op(addr, wd, wen, wmask, rt, mrd,
               wen ? 32'h0 : model_load(mrd, off, rt),
               wen ? model_strb(wmask, off) : 4'h0,
               model_wdata(wd, off), 1'b0,
               $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
